// File: rtl/v2_trap_filter.sv
// Programmable pole-zero / trapezoidal shaper for the ADC sample stream.
// Five-stage pipeline over a pointer-addressed delay buffer, with validated runtime config and flush.
module v2_trap_filter #(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned M_W    = 8,
  parameter int unsigned K_DEF  = 8,
  parameter int unsigned L_DEF  = 5,
  parameter int unsigned M_DEF  = 16,
  parameter int unsigned SH_DEF = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            input_data,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_k,
  input  logic [$clog2(DEPTH)-1:0]   cfg_l,
  input  logic [M_W-1:0]             cfg_m,
  input  logic [4:0]                 cfg_shift,
  output logic                       cfg_err,
  output logic                       busy,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    output_data,
  output logic                       out_sat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic {ST_FLUSH, ST_RUN} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic [PTR_W-1:0]         k_q, k_d, l_q, l_d;
  logic [M_W-1:0]           m_q, m_d;
  logic [4:0]               shift_q, shift_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic signed [ACC_W-1:0]  d1_q, d1_d, p_q, p_d, md2_q, md2_d, r3_q, r3_d, s_q, s_d;
  logic                     out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic signed [OUT_W-1:0]  output_data_q, output_data_d;
  logic                     cfg_err_q, cfg_err_d, busy_q, busy_d;

  logic [IN_W-1:0]          sample_mem [DEPTH];
  logic                     cfg_ok_c, accept_c, mem_we_c;
  logic [CNT_W-1:0]         cfg_sum_c, kl_sum_c, cnt_inc_c;
  logic [PTR_W-1:0]         rd_k_c, rd_l_c, rd_kl_c;
  logic signed [ACC_W-1:0]  d_c, md_c, sh_c;

  // Circular-buffer address ptr - off (mod DEPTH), off < DEPTH.
  function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] off);
    logic [CNT_W-1:0] diff;
    diff = {1'b0, ptr} - off;
    if ({1'b0, ptr} < off) diff = diff + CNT_W'(DEPTH);
    return diff[PTR_W-1:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    k_d           = k_q;
    l_d           = l_q;
    m_d           = m_q;
    shift_d       = shift_q;
    wr_ptr_d      = wr_ptr_q;
    v1_d          = 1'b0;
    d1_d          = d1_q;
    v2_d          = v1_q;
    md2_d         = md_c;
    p_d           = p_q;
    v3_d          = v2_q;
    r3_d          = p_q + md2_q;
    v4_d          = v3_q;
    s_d           = s_q;
    out_valid_d   = v4_q && (state_q == ST_RUN);
    output_data_d = output_data_q;
    out_sat_d     = 1'b0;

    cfg_sum_c = CNT_W'(cfg_k) + CNT_W'(cfg_l);
    cfg_ok_c  = cfg_we && (cfg_k != '0) && (cfg_l != '0) && (cfg_sum_c <= CNT_W'(DEPTH - 1));
    cfg_err_d = cfg_we && !cfg_ok_c;
    accept_c  = in_valid && !cfg_ok_c;
    mem_we_c  = accept_c && !reset;

    kl_sum_c  = CNT_W'(k_q) + CNT_W'(l_q);
    cnt_inc_c = flush_cnt_q + CNT_W'(1);
    rd_k_c    = ptr_sub(wr_ptr_q, CNT_W'(k_q));
    rd_l_c    = ptr_sub(wr_ptr_q, CNT_W'(l_q));
    rd_kl_c   = ptr_sub(wr_ptr_q, kl_sum_c);

    // S1: difference against delayed taps; incoming sample feeds d directly.
    d_c  = ACC_W'(input_data) - ACC_W'(sample_mem[rd_k_c]) - ACC_W'(sample_mem[rd_l_c])
         + ACC_W'(sample_mem[rd_kl_c]);
    md_c = ACC_W'(d1_q * $signed(ACC_W'(m_q)));
    sh_c = s_q >>> shift_q;

    if (accept_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      d1_d     = d_c;
      v1_d     = (state_q == ST_RUN);
    end

    if (v1_q) p_d = p_q + d1_q;
    if (v3_q) s_d = s_q + r3_q;

    if (v4_q) begin
      if (sh_c > SAT_MAX) begin
        output_data_d = OUT_W'(SAT_MAX);
        out_sat_d     = 1'b1;
      end else if (sh_c < SAT_MIN) begin
        output_data_d = OUT_W'(SAT_MIN);
        out_sat_d     = 1'b1;
      end else begin
        output_data_d = sh_c[OUT_W-1:0];
      end
    end

    // Flush: fill K+L taps before accumulating; accumulators pinned at zero.
    if (state_q == ST_FLUSH) begin
      p_d = '0;
      s_d = '0;
      if (accept_c) begin
        flush_cnt_d = cnt_inc_c;
        if (cnt_inc_c == kl_sum_c) state_d = ST_RUN;
      end
    end

    if (cfg_ok_c) begin
      k_d         = cfg_k;
      l_d         = cfg_l;
      m_d         = cfg_m;
      shift_d     = cfg_shift;
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      p_d         = '0;
      s_d         = '0;
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      v3_d        = 1'b0;
      v4_d        = 1'b0;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end

    busy_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FLUSH;
      flush_cnt_q   <= '0;
      k_q           <= PTR_W'(K_DEF);
      l_q           <= PTR_W'(L_DEF);
      m_q           <= M_W'(M_DEF);
      shift_q       <= 5'(SH_DEF);
      wr_ptr_q      <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      v3_q          <= 1'b0;
      v4_q          <= 1'b0;
      d1_q          <= '0;
      p_q           <= '0;
      md2_q         <= '0;
      r3_q          <= '0;
      s_q           <= '0;
      out_valid_q   <= 1'b0;
      output_data_q <= '0;
      out_sat_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      k_q           <= k_d;
      l_q           <= l_d;
      m_q           <= m_d;
      shift_q       <= shift_d;
      wr_ptr_q      <= wr_ptr_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      v3_q          <= v3_d;
      v4_q          <= v4_d;
      d1_q          <= d1_d;
      p_q           <= p_d;
      md2_q         <= md2_d;
      r3_q          <= r3_d;
      s_q           <= s_d;
      out_valid_q   <= out_valid_d;
      output_data_q <= output_data_d;
      out_sat_q     <= out_sat_d;
      cfg_err_q     <= cfg_err_d;
      busy_q        <= busy_d;
    end
  end

  // Delay buffer survives reset; only accepted samples are written.
  always_ff @(posedge clk) begin
    if (mem_we_c) sample_mem[wr_ptr_q] <= input_data;
  end

  assign cfg_err     = cfg_err_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign output_data = output_data_q;
  assign out_sat     = out_sat_q;

endmodule

// File: tb/tb_v2_trap_filter.sv
// Directed bench for v2_trap_filter: behavioural model feeds a cycle-stamped scoreboard.
module tb_v2_trap_filter;

  localparam int unsigned IN_W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, in_valid, cfg_we;
  logic [IN_W-1:0]    input_data;
  logic [5:0]         cfg_k, cfg_l;
  logic [7:0]         cfg_m;
  logic [4:0]         cfg_shift;
  logic               cfg_err, busy, out_valid, out_sat;
  logic signed [15:0] output_data;

  v2_trap_filter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_data(input_data),
    .cfg_we(cfg_we), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_shift(cfg_shift),
    .cfg_err(cfg_err), .busy(busy), .out_valid(out_valid),
    .output_data(output_data), .out_sat(out_sat)
  );

  typedef struct { int due; int data; logic sat; } exp_t;

  exp_t sb[$];
  int   cap_d[$];
  logic cap_s[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  int   mk, ml, mm, msh, mcnt, mp, ms;
  bit   mflush;
  int   mh[$];

  int pulse_ref[10] = '{1062, 1125, 1187, 1250, 1312, 312, 312, 312, -750, -813};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drop expectations for samples still in flight at cycle cyc.
  task automatic purge();
    while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
  endtask

  task automatic model_reset_cfg(input int k, input int l, input int m, input int sh);
    mk = k; ml = l; mm = m; msh = sh;
    mflush = 1'b1; mcnt = 0; mp = 0; ms = 0;
    mh.delete();
    purge();
  endtask

  task automatic model_accept(input int v);
    int n, dd, shv;
    exp_t e;
    mh.push_back(v);
    if (mh.size() > 200) void'(mh.pop_front());
    if (mflush) begin
      mcnt++;
      if (mcnt == mk + ml) mflush = 1'b0;
    end else begin
      n   = mh.size() - 1;
      dd  = mh[n] - mh[n-mk] - mh[n-ml] + mh[n-mk-ml];
      mp  = mp + dd;
      ms  = ms + mp + mm * dd;
      shv = ms >>> msh;
      e.due = cyc + 5;
      if (shv > 32767)       begin e.data = 32767;  e.sat = 1'b1; end
      else if (shv < -32768) begin e.data = -32768; e.sat = 1'b1; end
      else                   begin e.data = shv;    e.sat = 1'b0; end
      sb.push_back(e);
    end
  endtask

  task automatic step(input bit rst, input bit cfg, input int k, input int l, input int m,
                      input int sh, input bit v, input int d);
    int exp_err;
    bit cfg_ok;
    reset = rst; cfg_we = cfg; in_valid = v; input_data = IN_W'(d);
    cfg_k = 6'(k); cfg_l = 6'(l); cfg_m = 8'(m); cfg_shift = 5'(sh);
    exp_err = 0;
    cfg_ok  = cfg && k >= 1 && l >= 1 && (k + l) <= 63;
    if (rst) model_reset_cfg(8, 5, 16, 4);
    else begin
      if (cfg && !cfg_ok) exp_err = 1;
      if (cfg_ok) model_reset_cfg(k, l, m, sh);
      else if (v) model_accept(d);
    end
    @(posedge clk); #1;
    reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    chk("busy", busy, mflush);
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic samp(input int d);                   step(0, 0, 0, 0, 0, 0, 1, d); endtask
  task automatic idle(input int n);                   repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_rst();                            step(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_cfg(input int k, input int l, input int m, input int sh, input bit v, input int d);
    step(0, 1, k, l, m, sh, v, d);
  endtask

  // Output monitor: every out_valid must match the next due expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      cap_d.push_back(int'(output_data));
      cap_s.push_back(out_sat);
      chk("out_valid_while_busy", busy, 0);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("output_data", output_data, e.data);
        chk("out_sat", out_sat, e.sat);
      end else begin
        chk("out_valid_unexpected", out_valid, 0);
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("out_valid_missing", out_valid, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    int mn;
    logic mn_sat;
    reset = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; input_data = '0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0;

    do_rst();
    do_rst();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_output_data", output_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cfg_err", cfg_err, 0);

    // Flush at baseline 100, then steady state
    repeat (30) samp(100);

    // Single-sample excursion to 1100 over a 100 baseline
    idle(6);
    cap_d.delete(); cap_s.delete();
    samp(1100);
    repeat (15) samp(100);
    idle(6);
    chk("pulse_len", cap_d.size(), 16);
    for (int i = 0; i < 10; i++) begin
      if (i < cap_d.size()) begin
        chk("pulse_data", cap_d[i], pulse_ref[i]);
        chk("pulse_sat", cap_s[i], 0);
      end
    end

    // Sustained step, defaults
    repeat (30) samp(1100);

    // Rejected config (K+L too large): no flush, old coefficients kept
    do_cfg(20, 50, 3, 1, 0, 0);
    for (int i = 0; i < 12; i++) samp(1100 + i * 7);

    // Accepted config mid-stream with a coincident sample, then restart while busy
    do_cfg(4, 3, 0, 0, 1, 2000);
    samp(500); samp(600); samp(700);
    do_cfg(4, 3, 0, 0, 1, 900);
    repeat (7) samp(500);
    repeat (10) samp(500);
    for (int i = 0; i < 12; i++) samp(500 + 37 * i);
    idle(6);

    // Saturation with shift 0
    do_cfg(8, 5, 16, 0, 0, 0);
    repeat (18) samp(0);
    idle(6);
    cap_d.delete(); cap_s.delete();
    repeat (30) samp(4095);
    repeat (30) samp(0);
    idle(6);
    chk("sat_len", cap_d.size(), 60);
    if (cap_d.size() > 0) begin
      chk("sat_pos_data", cap_d[0], 32767);
      chk("sat_pos_flag", cap_s[0], 1);
    end
    mn = 0; mn_sat = 1'b0;
    for (int i = 0; i < cap_d.size(); i++)
      if (cap_d[i] < mn) begin mn = cap_d[i]; mn_sat = cap_s[i]; end
    chk("sat_neg_data", mn, -32768);
    chk("sat_neg_flag", mn_sat, 1);

    // Reset mid-stream restores defaults and a fresh 13-sample flush
    repeat (8) samp(int'($urandom_range(0, 4095)));
    do_rst();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_output_data", output_data, 0);
    chk("mid_rst_busy", busy, 1);
    repeat (33) samp(int'($urandom_range(0, 4095)));
    idle(8);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
